// File: rtl/trigger_order_launcher.sv
// Order launcher behind the price trigger stage: fires one order per fresh
// trigger rising edge while armed, with post-order cooldown and a fire-count lockout.
module trigger_order_launcher #(
    parameter int PRICE_W   = 8,
    parameter int QTY_W     = 8,
    parameter int COOLDOWN  = 4,
    parameter int MAX_FIRES = 3,
    parameter int CNT_W     = $clog2(MAX_FIRES + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic               disarm,
    input  logic               trigger_satisfied,
    input  logic               trigger_side,
    input  logic [PRICE_W-1:0] cfg_price,
    input  logic [QTY_W-1:0]   cfg_qty,
    output logic               order_valid,
    input  logic               order_ready,
    output logic               order_side,
    output logic [PRICE_W-1:0] order_price,
    output logic [QTY_W-1:0]   order_qty,
    output logic               armed,
    output logic               limit_reached,
    output logic [CNT_W-1:0]   fire_count
);

    localparam int CD_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int CD_LOAD = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_FIRES);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_FIRES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_SEND, S_COOL, S_LOCKED
    } state_t;

    state_t             state_q;
    logic               sat_prev_q;
    logic [CD_W-1:0]    cd_q;
    logic               pend_q;
    logic               valid_q;
    logic               side_q;
    logic [PRICE_W-1:0] price_q;
    logic [QTY_W-1:0]   qty_q;
    logic [CNT_W-1:0]   fire_q;
    logic               armed_q;
    logic               lim_q;

    logic rise;
    assign rise = trigger_satisfied & ~sat_prev_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sat_prev_q <= 1'b0;
            cd_q       <= '0;
            pend_q     <= 1'b0;
            valid_q    <= 1'b0;
            side_q     <= 1'b0;
            price_q    <= '0;
            qty_q      <= '0;
            fire_q     <= '0;
            armed_q    <= 1'b0;
            lim_q      <= 1'b0;
        end else begin
            sat_prev_q <= trigger_satisfied;
            case (state_q)
                S_IDLE: begin
                    if (arm && !disarm) begin
                        state_q <= S_ARMED;
                        armed_q <= 1'b1;
                        fire_q  <= '0;
                    end
                end
                S_ARMED: begin
                    if (disarm) begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b0;
                    end else if (rise) begin
                        state_q <= S_SEND;
                        valid_q <= 1'b1;
                        side_q  <= trigger_side;
                        price_q <= cfg_price;
                        qty_q   <= cfg_qty;
                    end
                end
                S_SEND: begin
                    // The order is never withdrawn; a disarm only takes effect after the transfer.
                    if (order_ready) begin
                        valid_q <= 1'b0;
                        pend_q  <= 1'b0;
                        if (fire_q != MAX_C) fire_q <= fire_q + 1'b1;
                        if (pend_q || disarm) begin
                            state_q <= S_IDLE;
                            armed_q <= 1'b0;
                        end else if (fire_q == LAST_C) begin
                            state_q <= S_LOCKED;
                            armed_q <= 1'b0;
                            lim_q   <= 1'b1;
                        end else if (COOLDOWN == 0) begin
                            state_q <= S_ARMED;
                        end else begin
                            state_q <= S_COOL;
                            cd_q    <= CD_W'(CD_LOAD);
                        end
                    end else if (disarm) begin
                        pend_q <= 1'b1;
                    end
                end
                S_COOL: begin
                    if (disarm) begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b0;
                    end else if (cd_q == '0) begin
                        state_q <= S_ARMED;
                    end else begin
                        cd_q <= cd_q - 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (disarm) begin
                        state_q <= S_IDLE;
                        lim_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    armed_q <= 1'b0;
                    lim_q   <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign order_valid   = valid_q;
    assign order_side    = side_q;
    assign order_price   = price_q;
    assign order_qty     = qty_q;
    assign armed         = armed_q;
    assign limit_reached = lim_q;
    assign fire_count    = fire_q;

endmodule
